// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and downstream hold.
// Optional hazard/bubble statistics counters are enabled by defining HAZARD_STATS_EN.
module id_ex_stage #(
    parameter int DATA_W   = 32,
    parameter int ALUCTR_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [4:0]          id_Ra,
    input  logic [4:0]          id_Rb,
    input  logic                id_useRa,
    input  logic                id_useRb,
    input  logic [4:0]          id_Rw,
    input  logic                id_RegWr,
    input  logic                id_MemWr,
    input  logic                id_MemtoReg,
    input  logic                id_ALUSrc,
    input  logic [ALUCTR_W-1:0] id_ALUctr,
    input  logic [DATA_W-1:0]   id_busA,
    input  logic [DATA_W-1:0]   id_busB,
    input  logic [DATA_W-1:0]   id_imm32,
    input  logic                flush,
    input  logic                hold,
    output logic                ex_valid,
    output logic [4:0]          ex_Ra,
    output logic [4:0]          ex_Rb,
    output logic [4:0]          ex_Rw,
    output logic                ex_RegWr,
    output logic                ex_MemWr,
    output logic                ex_MemtoReg,
    output logic                ex_ALUSrc,
    output logic [ALUCTR_W-1:0] ex_ALUctr,
    output logic [DATA_W-1:0]   ex_busA,
    output logic [DATA_W-1:0]   ex_busB,
    output logic [DATA_W-1:0]   ex_imm32,
    output logic                stall
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]    hazard_cnt,
    output logic [CNT_W-1:0]    bubble_cnt
`endif
);

    typedef struct packed {
        logic                valid;
        logic [4:0]          ra;
        logic [4:0]          rb;
        logic [4:0]          rw;
        logic                regwr;
        logic                memwr;
        logic                memtoreg;
        logic                alusrc;
        logic [ALUCTR_W-1:0] aluctr;
        logic [DATA_W-1:0]   bus_a;
        logic [DATA_W-1:0]   bus_b;
        logic [DATA_W-1:0]   imm32;
    } ex_fields_t;

    ex_fields_t ex_r;
    ex_fields_t id_s;
    logic       load_in_ex_s;
    logic       src_match_s;
    logic       lu_s;
    logic       bubble_s;

    // Pack the decoded instruction into the pipeline register layout.
    always_comb begin
        id_s.valid    = id_valid;
        id_s.ra       = id_Ra;
        id_s.rb       = id_Rb;
        id_s.rw       = id_Rw;
        id_s.regwr    = id_RegWr;
        id_s.memwr    = id_MemWr;
        id_s.memtoreg = id_MemtoReg;
        id_s.alusrc   = id_ALUSrc;
        id_s.aluctr   = id_ALUctr;
        id_s.bus_a    = id_busA;
        id_s.bus_b    = id_busB;
        id_s.imm32    = id_imm32;
    end

    // Load-use detection: a real load in EX writing a nonzero register that ID reads.
    always_comb begin
        load_in_ex_s = ex_r.valid & ex_r.regwr & ex_r.memtoreg & (ex_r.rw != 5'd0);
        src_match_s  = (id_useRa & (id_Ra == ex_r.rw)) | (id_useRb & (id_Rb == ex_r.rw));
        lu_s         = load_in_ex_s & id_valid & src_match_s;
    end

    // Stall PC/IF-ID on hold or an unflushed hazard; quiet while reset is asserted.
    always_comb begin
        if (reset) begin
            stall = 1'b0;
        end else begin
            stall = hold | (lu_s & ~flush);
        end
    end

    assign bubble_s = flush | lu_s;

    // Pipeline register: reset > hold > bubble (flush or load-use) > load from ID.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_r <= '0;
        end else if (hold) begin
            ex_r <= ex_r;
        end else if (bubble_s) begin
            ex_r <= '0;
        end else begin
            ex_r <= id_s;
        end
    end

    assign ex_valid    = ex_r.valid;
    assign ex_Ra       = ex_r.ra;
    assign ex_Rb       = ex_r.rb;
    assign ex_Rw       = ex_r.rw;
    assign ex_RegWr    = ex_r.regwr;
    assign ex_MemWr    = ex_r.memwr;
    assign ex_MemtoReg = ex_r.memtoreg;
    assign ex_ALUSrc   = ex_r.alusrc;
    assign ex_ALUctr   = ex_r.aluctr;
    assign ex_busA     = ex_r.bus_a;
    assign ex_busB     = ex_r.bus_b;
    assign ex_imm32    = ex_r.imm32;

`ifdef HAZARD_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] hazard_cnt_r;
    logic [CNT_W-1:0] bubble_cnt_r;
    logic             hazard_inc_s;
    logic             bubble_inc_s;

    assign hazard_inc_s = lu_s & ~flush & ~hold;
    assign bubble_inc_s = bubble_s & ~hold;

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            hazard_cnt_r <= '0;
            bubble_cnt_r <= '0;
        end else begin
            if (hazard_inc_s && (hazard_cnt_r != CNT_MAX)) begin
                hazard_cnt_r <= hazard_cnt_r + CNT_ONE;
            end
            if (bubble_inc_s && (bubble_cnt_r != CNT_MAX)) begin
                bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
            end
        end
    end

    assign hazard_cnt = hazard_cnt_r;
    assign bubble_cnt = bubble_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// against a cycle-level reference model derived from the stage's priority rules.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rw;
        logic        regwr;
        logic        memwr;
        logic        memtoreg;
        logic        alusrc;
        logic [3:0]  aluctr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
    } ex_t;

    logic clk;
    logic reset;
    logic flush;
    logic hold;
    logic use_ra;
    logic use_rb;
    ex_t  idv;

    logic        ex_valid, ex_RegWr, ex_MemWr, ex_MemtoReg, ex_ALUSrc, stall;
    logic [4:0]  ex_Ra, ex_Rb, ex_Rw;
    logic [3:0]  ex_ALUctr;
    logic [31:0] ex_busA, ex_busB, ex_imm32;
    ex_t         dut_ex;

`ifdef HAZARD_STATS_EN
    logic [15:0] hazard_cnt, bubble_cnt;
    int          exp_hcnt, exp_bcnt;
`endif

    ex_t model;
    int  n_tests;
    int  n_fail;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(idv.valid), .id_Ra(idv.ra), .id_Rb(idv.rb),
        .id_useRa(use_ra), .id_useRb(use_rb), .id_Rw(idv.rw),
        .id_RegWr(idv.regwr), .id_MemWr(idv.memwr), .id_MemtoReg(idv.memtoreg),
        .id_ALUSrc(idv.alusrc), .id_ALUctr(idv.aluctr),
        .id_busA(idv.a), .id_busB(idv.b), .id_imm32(idv.imm),
        .flush(flush), .hold(hold),
        .ex_valid(ex_valid), .ex_Ra(ex_Ra), .ex_Rb(ex_Rb), .ex_Rw(ex_Rw),
        .ex_RegWr(ex_RegWr), .ex_MemWr(ex_MemWr), .ex_MemtoReg(ex_MemtoReg),
        .ex_ALUSrc(ex_ALUSrc), .ex_ALUctr(ex_ALUctr),
        .ex_busA(ex_busA), .ex_busB(ex_busB), .ex_imm32(ex_imm32),
        .stall(stall)
`ifdef HAZARD_STATS_EN
        , .hazard_cnt(hazard_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    assign dut_ex = {ex_valid, ex_Ra, ex_Rb, ex_Rw, ex_RegWr, ex_MemWr, ex_MemtoReg,
                     ex_ALUSrc, ex_ALUctr, ex_busA, ex_busB, ex_imm32};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_lu();
        logic is_load;
        is_load = model.valid && model.regwr && model.memtoreg && (model.rw != 5'd0);
        return is_load && idv.valid &&
               ((use_ra && idv.ra == model.rw) || (use_rb && idv.rb == model.rw));
    endfunction

    function automatic logic model_stall();
        return !reset && (hold || (model_lu() && !flush));
    endfunction

    function automatic ex_t rand_id();
        ex_t r;
        r.valid    = 1'($urandom_range(0, 3) != 0);
        r.ra       = 5'($urandom_range(0, 3));
        r.rb       = 5'($urandom_range(0, 3));
        r.rw       = 5'($urandom_range(0, 3));
        r.regwr    = 1'($urandom);
        r.memwr    = 1'($urandom);
        r.memtoreg = 1'($urandom);
        r.alusrc   = 1'($urandom);
        r.aluctr   = 4'($urandom);
        r.a        = 32'($urandom);
        r.b        = 32'($urandom);
        r.imm      = 32'($urandom);
        return r;
    endfunction

    // Advance one clock, updating the reference model from pre-edge inputs.
    task automatic clock_cycle();
        ex_t nxt;
        logic lu;
        lu = model_lu();
        if (reset)              nxt = '0;
        else if (hold)          nxt = model;
        else if (flush || lu)   nxt = '0;
        else                    nxt = idv;
`ifdef HAZARD_STATS_EN
        if (reset) begin
            exp_hcnt = 0;
            exp_bcnt = 0;
        end else begin
            if (lu && !flush && !hold && exp_hcnt < 65535) exp_hcnt++;
            if ((flush || lu) && !hold && exp_bcnt < 65535) exp_bcnt++;
        end
`endif
        @(posedge clk);
        #1;
        model = nxt;
    endtask

    task automatic drive_load(input logic [4:0] rw);
        idv = '0;
        idv.valid = 1'b1; idv.rw = rw; idv.regwr = 1'b1; idv.memtoreg = 1'b1;
        idv.a = 32'hA5A5_0001;
        use_ra = 1'b1; use_rb = 1'b0;
        flush = 1'b0; hold = 1'b0;
        clock_cycle();
    endtask

    task automatic test_reset();
        reset = 1'b1; hold = 1'b0; flush = 1'b0;
        idv = rand_id(); use_ra = 1'b1; use_rb = 1'b1;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b expected 0", stall);
        end
        clock_cycle();
        n_tests++;
        if (dut_ex !== 120'd0) begin
            n_fail++; $display("FAIL reset_ex: got %h expected 0", dut_ex);
        end
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall_after: got %b expected 0", stall);
        end
`ifdef HAZARD_STATS_EN
        n_tests++;
        if (hazard_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", hazard_cnt, bubble_cnt);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_plain_flow();
        idv = '0;
        idv.valid = 1'b1; idv.rw = 5'd5; idv.regwr = 1'b1; idv.a = 32'h1234;
        use_ra = 1'b0; use_rb = 1'b0;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL flow_stall_pre: got %b expected 0", stall);
        end
        clock_cycle();
        n_tests++;
        if (ex_Rw !== 5'd5 || ex_busA !== 32'h1234 || ex_valid !== 1'b1 || ex_RegWr !== 1'b1) begin
            n_fail++; $display("FAIL flow_ex: got rw=%0d busA=%h valid=%b expected 5/1234/1", ex_Rw, ex_busA, ex_valid);
        end
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL flow_stall_post: got %b expected 0", stall);
        end
    endtask

    task automatic test_load_use();
        drive_load(5'd8);
        idv = '0;
        idv.valid = 1'b1; idv.ra = 5'd8; idv.rw = 5'd9; idv.regwr = 1'b1; idv.b = 32'h77;
        use_ra = 1'b1; use_rb = 1'b0;
        #1;
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL lu_stall: got %b expected 1", stall);
        end
        clock_cycle();
        n_tests++;
        if (dut_ex !== 120'd0) begin
            n_fail++; $display("FAIL lu_bubble: got %h expected 0", dut_ex);
        end
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL lu_stall_released: got %b expected 0", stall);
        end
        clock_cycle();
        n_tests++;
        if (ex_Ra !== 5'd8 || ex_valid !== 1'b1 || ex_Rw !== 5'd9 || ex_busB !== 32'h77) begin
            n_fail++; $display("FAIL lu_reenter: got ra=%0d valid=%b rw=%0d expected 8/1/9", ex_Ra, ex_valid, ex_Rw);
        end
        // A store whose data register Rb is the loaded register must also stall.
        drive_load(5'd8);
        idv = '0;
        idv.valid = 1'b1; idv.rb = 5'd8; idv.ra = 5'd2; idv.memwr = 1'b1;
        use_ra = 1'b1; use_rb = 1'b1;
        #1;
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++; $display("FAIL lu_store_rb: got %b expected 1", stall);
        end
        clock_cycle();
    endtask

    task automatic test_no_false_stall();
        drive_load(5'd0);
        idv = '0; idv.valid = 1'b1; idv.ra = 5'd0;
        use_ra = 1'b1; use_rb = 1'b0;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL nofalse_rw0: got %b expected 0", stall);
        end
        drive_load(5'd8);
        idv = '0; idv.valid = 1'b1; idv.ra = 5'd3; idv.rb = 5'd8;
        use_ra = 1'b1; use_rb = 1'b0;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL nofalse_unused_rb: got %b expected 0", stall);
        end
        idv.valid = 1'b0; idv.ra = 5'd8; use_ra = 1'b1;
        #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL nofalse_invalid_id: got %b expected 0", stall);
        end
        clock_cycle();
        n_tests++;
        if (ex_valid !== 1'b0 || ex_Ra !== 5'd8) begin
            n_fail++; $display("FAIL invalid_loaded: got valid=%b ra=%0d expected 0/8", ex_valid, ex_Ra);
        end
    endtask

    task automatic test_flush_beats_hazard();
`ifdef HAZARD_STATS_EN
        logic [15:0] h0, b0;
`endif
        drive_load(5'd8);
        idv = '0; idv.valid = 1'b1; idv.ra = 5'd8; idv.rw = 5'd4; idv.regwr = 1'b1;
        use_ra = 1'b1; use_rb = 1'b0; flush = 1'b1;
`ifdef HAZARD_STATS_EN
        h0 = hazard_cnt; b0 = bubble_cnt;
`endif
        #1;
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_stall: got %b expected 0", stall);
        end
        clock_cycle();
        flush = 1'b0;
        n_tests++;
        if (dut_ex !== 120'd0) begin
            n_fail++; $display("FAIL flush_bubble: got %h expected 0", dut_ex);
        end
`ifdef HAZARD_STATS_EN
        n_tests++;
        if (bubble_cnt !== b0 + 16'd1 || hazard_cnt !== h0) begin
            n_fail++; $display("FAIL flush_cnt: got h=%0d b=%0d expected h=%0d b=%0d", hazard_cnt, bubble_cnt, h0, b0 + 16'd1);
        end
`endif
    endtask

    task automatic test_hold();
        ex_t snap;
        ex_t nxt_id;
        idv = rand_id(); idv.valid = 1'b1; idv.memtoreg = 1'b0;
        use_ra = 1'b0; use_rb = 1'b0; flush = 1'b0; hold = 1'b0;
        snap = idv;
        clock_cycle();
        for (int i = 0; i < 3; i++) begin
            hold = 1'b1;
            idv = rand_id(); use_ra = 1'b1; flush = 1'(i == 1);
            #1;
            n_tests++;
            if (stall !== 1'b1) begin
                n_fail++; $display("FAIL hold_stall[%0d]: got %b expected 1", i, stall);
            end
            clock_cycle();
            n_tests++;
            if (dut_ex !== snap) begin
                n_fail++; $display("FAIL hold_frozen[%0d]: got %h expected %h", i, dut_ex, snap);
            end
        end
        hold = 1'b0; flush = 1'b0; use_ra = 1'b0; use_rb = 1'b0;
        nxt_id = rand_id();
        idv = nxt_id;
        clock_cycle();
        n_tests++;
        if (dut_ex !== nxt_id) begin
            n_fail++; $display("FAIL hold_release: got %h expected %h", dut_ex, nxt_id);
        end
        hold = 1'b1; reset = 1'b1; idv = rand_id();
        clock_cycle();
        n_tests++;
        if (dut_ex !== 120'd0) begin
            n_fail++; $display("FAIL hold_reset: got %h expected 0", dut_ex);
        end
        hold = 1'b0; reset = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            idv    = rand_id();
            use_ra = 1'($urandom);
            use_rb = 1'($urandom);
            flush  = 1'($urandom_range(0, 7) == 0);
            hold   = 1'($urandom_range(0, 7) == 0);
            reset  = 1'($urandom_range(0, 59) == 0);
            #1;
            n_tests++;
            if (stall !== model_stall()) begin
                n_fail++; $display("FAIL rand_stall[%0d]: got %b expected %b", i, stall, model_stall());
            end
            clock_cycle();
            n_tests++;
            if (dut_ex !== model) begin
                n_fail++; $display("FAIL rand_ex[%0d]: got %h expected %h", i, dut_ex, model);
            end
`ifdef HAZARD_STATS_EN
            n_tests++;
            if (hazard_cnt !== 16'(exp_hcnt) || bubble_cnt !== 16'(exp_bcnt)) begin
                n_fail++; $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, hazard_cnt, bubble_cnt, exp_hcnt, exp_bcnt);
            end
`endif
        end
        reset = 1'b0; hold = 1'b0; flush = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model   = '0;
`ifdef HAZARD_STATS_EN
        exp_hcnt = 0;
        exp_bcnt = 0;
`endif
        reset = 1'b1; hold = 1'b0; flush = 1'b0;
        use_ra = 1'b0; use_rb = 1'b0; idv = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_plain_flow();
        test_load_use();
        test_no_false_stall();
        test_flush_beats_hazard();
        test_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
